// File: rtl/graphics_pkg.sv
// Shared screen geometry, pixel types and depth-tester state encodings for the
// fragment back end.
package graphics_pkg;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 240;
    localparam int FB_ADDR_W     = 17;
    localparam int Z_W           = 8;
    localparam int RGB_W         = 12;
    localparam int X_W           = 9;
    localparam int Y_W           = 8;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [Z_W-1:0]   z;
        logic [RGB_W-1:0] rgb;
    } fragment_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } clear_state_t;

    // Fragment in flight towards the compare stage; hit/zs carry a forwarded depth
    // that overrides the (possibly stale) z-buffer read.
    typedef struct packed {
        fb_addr_t         addr;
        logic [Z_W-1:0]   z;
        logic [RGB_W-1:0] rgb;
        logic             hit;
        logic [Z_W-1:0]   zs;
    } stage_t;

    typedef struct packed {
        fb_addr_t         addr;
        logic [Z_W-1:0]   z;
        logic [RGB_W-1:0] rgb;
        logic [Z_W-1:0]   zs;
    } cmp_t;

endpackage

// File: rtl/zbuffer_ram.sv
// Single-clock simple dual-port depth store; reads return the value held before
// any same-cycle write, delayed by LATENCY register stages.
module zbuffer_ram
    import graphics_pkg::*;
#(
    parameter int DEPTH   = SCREEN_WIDTH * SCREEN_HEIGHT,
    parameter int LATENCY = 2,
    parameter int DATA_W  = Z_W
) (
    input  logic                 clk_in,
    input  logic                 wr_en,
    input  logic [FB_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [FB_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]    rd_data
);

    logic [DATA_W-1:0] mem  [0:DEPTH-1];
    logic [DATA_W-1:0] rd_p [0:LATENCY-1];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_p[0] <= mem[rd_addr];
        for (int k = 1; k < LATENCY; k++) begin
            rd_p[k] <= rd_p[k-1];
        end
    end

    assign rd_data = rd_p[LATENCY-1];

endmodule

// File: rtl/depth_tester.sv
// Per-pixel depth test with write-through z-buffer, hazard forwarding and a
// frame-start clear sweep of both z-buffer and framebuffer.
module depth_tester
    import graphics_pkg::*;
#(
    parameter int             WIDTH       = SCREEN_WIDTH,
    parameter int             HEIGHT      = SCREEN_HEIGHT,
    parameter int             RAM_LATENCY = 2,
    parameter logic [Z_W-1:0] Z_FAR       = 8'hFF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    input  logic [X_W-1:0]       x_in,
    input  logic [Y_W-1:0]       y_in,
    input  logic [Z_W-1:0]       z_in,
    input  logic [RGB_W-1:0]     rgb_in,
    output logic                 ready_out,
    input  logic                 clear_in,
    input  logic [RGB_W-1:0]     bg_rgb_in,
    output logic                 busy_out,
    output logic                 clear_done_out,
    output logic                 fb_we_out,
    output logic [FB_ADDR_W-1:0] fb_addr_out,
    output logic [RGB_W-1:0]     fb_data_out
);

    localparam int       NPIX      = WIDTH * HEIGHT;
    localparam fb_addr_t LAST_ADDR = fb_addr_t'(NPIX - 1);

    function automatic fb_addr_t pixel_addr(input fragment_t f);
        return fb_addr_t'(32'(f.y) * WIDTH + 32'(f.x));
    endfunction

    function automatic logic in_range(input fragment_t f);
        return (32'(f.x) < WIDTH) && (32'(f.y) < HEIGHT);
    endfunction

    fragment_t        frag_in;
    fb_addr_t         in_addr;
    logic             accept;
    clear_state_t     state_q, state_d;
    logic             clr_last;
    fb_addr_t         clr_cnt_q;
    logic [RGB_W-1:0] bg_q;
    logic             ready_q, busy_q, done_q;
    logic             fb_we_q;
    fb_addr_t         fb_addr_q;
    logic [RGB_W-1:0] fb_data_q;

    stage_t           stage_p [0:RAM_LATENCY];
    logic             vld_p   [0:RAM_LATENCY];
    cmp_t             stage_pc;
    logic             vld_pc;
    logic             c_pass;
    logic             pipe_empty;

    logic             ram_we;
    fb_addr_t         ram_waddr;
    logic [Z_W-1:0]   ram_wdata;
    logic [Z_W-1:0]   rd_z;

    assign frag_in = '{x: x_in, y: y_in, z: z_in, rgb: rgb_in};
    assign in_addr = pixel_addr(frag_in);
    assign accept  = valid_in && ready_q;
    assign c_pass  = vld_pc && (stage_pc.z < stage_pc.zs);

    always_comb begin
        pipe_empty = !vld_pc;
        for (int k = 0; k <= RAM_LATENCY; k++) begin
            if (vld_p[k]) begin
                pipe_empty = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        clr_last = 1'b0;
        case (state_q)
            IDLE:  if (clear_in) state_d = DRAIN;
            DRAIN: if (pipe_empty) state_d = CLEAR;
            CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    clr_last = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clr_cnt_q <= '0;
        end else begin
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
            done_q  <= clr_last;
            if (state_q == CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end else begin
                clr_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (state_q == IDLE && clear_in) begin
            bg_q <= bg_rgb_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int k = 0; k <= RAM_LATENCY; k++) begin
                vld_p[k] <= 1'b0;
            end
            vld_pc <= 1'b0;
        end else begin
            vld_p[0] <= accept && in_range(frag_in);
            for (int k = 1; k <= RAM_LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            vld_pc <= vld_p[RAM_LATENCY];
        end
    end

    // stage A: address, depth and colour registered; z-buffer read issued from here
    always_ff @(posedge clk_in) begin
        stage_p[0].addr <= in_addr;
        stage_p[0].z    <= frag_in.z;
        stage_p[0].rgb  <= frag_in.rgb;
        stage_p[0].hit  <= c_pass && (in_addr == stage_pc.addr);
        stage_p[0].zs   <= stage_pc.z;
        // read-wait stages: every in-flight copy of the written pixel picks up the new depth
        for (int k = 1; k <= RAM_LATENCY; k++) begin
            stage_p[k] <= stage_p[k-1];
            if (c_pass && stage_p[k-1].addr == stage_pc.addr) begin
                stage_p[k].hit <= 1'b1;
                stage_p[k].zs  <= stage_pc.z;
            end
        end
        // stage C: stored depth resolved from the newest write, forwarded value or RAM
        stage_pc.addr <= stage_p[RAM_LATENCY].addr;
        stage_pc.z    <= stage_p[RAM_LATENCY].z;
        stage_pc.rgb  <= stage_p[RAM_LATENCY].rgb;
        if (c_pass && stage_p[RAM_LATENCY].addr == stage_pc.addr) begin
            stage_pc.zs <= stage_pc.z;
        end else if (stage_p[RAM_LATENCY].hit) begin
            stage_pc.zs <= stage_p[RAM_LATENCY].zs;
        end else begin
            stage_pc.zs <= rd_z;
        end
    end

    always_comb begin
        ram_we    = c_pass;
        ram_waddr = stage_pc.addr;
        ram_wdata = stage_pc.z;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = Z_FAR;
        end
    end

    zbuffer_ram #(
        .DEPTH   (NPIX),
        .LATENCY (RAM_LATENCY),
        .DATA_W  (Z_W)
    ) u_zbuf (
        .clk_in  (clk_in),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (stage_p[0].addr),
        .rd_data (rd_z)
    );

    // framebuffer write port
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else if (state_q == CLEAR) begin
            fb_we_q   <= 1'b1;
            fb_addr_q <= clr_cnt_q;
            fb_data_q <= bg_q;
        end else begin
            fb_we_q <= c_pass;
            if (c_pass) begin
                fb_addr_q <= stage_pc.addr;
                fb_data_q <= stage_pc.rgb;
            end
        end
    end

    assign ready_out      = ready_q;
    assign busy_out       = busy_q;
    assign clear_done_out = done_q;
    assign fb_we_out      = fb_we_q;
    assign fb_addr_out    = fb_addr_q;
    assign fb_data_out    = fb_data_q;

endmodule

// File: tb/tb_depth_tester.sv
// Scoreboard bench for depth_tester: a serialised z-buffer model predicts every
// framebuffer write, and a negedge monitor checks them in order.
module tb_depth_tester;
    import graphics_pkg::*;

    localparam int NPIX = SCREEN_WIDTH * SCREEN_HEIGHT;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b0;
    logic                 valid_in = 1'b0;
    logic [X_W-1:0]       x_in = '0;
    logic [Y_W-1:0]       y_in = '0;
    logic [Z_W-1:0]       z_in = '0;
    logic [RGB_W-1:0]     rgb_in = '0;
    logic                 ready_out;
    logic                 clear_in = 1'b0;
    logic [RGB_W-1:0]     bg_rgb_in = '0;
    logic                 busy_out;
    logic                 clear_done_out;
    logic                 fb_we_out;
    logic [FB_ADDR_W-1:0] fb_addr_out;
    logic [RGB_W-1:0]     fb_data_out;

    depth_tester dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .valid_in       (valid_in),
        .x_in           (x_in),
        .y_in           (y_in),
        .z_in           (z_in),
        .rgb_in         (rgb_in),
        .ready_out      (ready_out),
        .clear_in       (clear_in),
        .bg_rgb_in      (bg_rgb_in),
        .busy_out       (busy_out),
        .clear_done_out (clear_done_out),
        .fb_we_out      (fb_we_out),
        .fb_addr_out    (fb_addr_out),
        .fb_data_out    (fb_data_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    logic [7:0] zb [0:NPIX-1];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (clear_done_out) done_cnt++;
        if (fb_we_out) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected",
                         fb_addr_out, fb_data_out);
            end else begin
                e = exp_q.pop_front();
                check("fb_addr", int'(fb_addr_out), e.addr);
                check("fb_data", int'(fb_data_out), e.data);
                if (e.cyc >= 0) check("fb_latency", cyc, e.cyc);
            end
        end
    end

    // Drive one fragment for one cycle; the model processes it fully serialised.
    task automatic send(input int x, input int y, input int z, input int rgb);
        int a;
        valid_in = 1'b1;
        x_in     = 9'(x);
        y_in     = 8'(y);
        z_in     = 8'(z);
        rgb_in   = 12'(rgb);
        if (x < SCREEN_WIDTH && y < SCREEN_HEIGHT) begin
            a = y * SCREEN_WIDTH + x;
            if (z < int'(zb[a])) begin
                zb[a] = 8'(z);
                exp_q.push_back('{a, rgb, cyc + 5});
            end
        end
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic start_clear(input int bg, input int n_expect);
        for (int i = 0; i < n_expect; i++) begin
            exp_q.push_back('{i, bg, -1});
            zb[i] = 8'hFF;
        end
        clear_in  = 1'b1;
        bg_rgb_in = 12'(bg);
        @(negedge clk_in);
        clear_in  = 1'b0;
    endtask

    task automatic abort_clear(input int bg, input int n);
        bit seen;
        seen = 1'b0;
        start_clear(bg, n);
        for (int i = 0; i < n + 100; i++) begin
            if (fb_we_out && busy_out && int'(fb_addr_out) == n - 1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        check("abort_point_reached", int'(seen), 1);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("abort_fb_we", int'(fb_we_out), 0);
        check("abort_busy", int'(busy_out), 0);
        check("abort_ready", int'(ready_out), 0);
        check("abort_done", int'(clear_done_out), 0);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("abort_ready_after", int'(ready_out), 1);
        check("abort_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit got_done;
        int x, y;

        for (int i = 0; i < NPIX; i++) zb[i] = 8'h00;

        idle(3);
        check("rst_ready", int'(ready_out), 0);
        check("rst_busy", int'(busy_out), 0);
        check("rst_done", int'(clear_done_out), 0);
        check("rst_fb_we", int'(fb_we_out), 0);
        check("rst_fb_addr", int'(fb_addr_out), 0);
        check("rst_fb_data", int'(fb_data_out), 0);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("ready_after_rst", int'(ready_out), 1);
        check("busy_after_rst", int'(busy_out), 0);

        start_clear(12'h00F, NPIX);
        check("clear_busy", int'(busy_out), 1);
        check("clear_ready", int'(ready_out), 0);
        got_done = 1'b0;
        for (int i = 0; i < NPIX + 100; i++) begin
            if (clear_done_out) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        check("clear_done_seen", int'(got_done), 1);
        @(negedge clk_in);
        check("clear_done_once", done_cnt, 1);
        check("clear_done_pulse_width", int'(clear_done_out), 0);
        check("ready_after_clear", int'(ready_out), 1);
        check("busy_after_clear", int'(busy_out), 0);
        check("clear_write_count", exp_q.size(), 0);

        send(10, 2, 8'h40, 12'hABC);
        idle(6);
        send(5, 5, 8'h80, 12'h111);
        send(5, 5, 8'h70, 12'h222);
        send(5, 5, 8'h70, 12'h333);
        idle(6);
        send(5, 5, 8'h30, 12'h444);
        send(5, 5, 8'h50, 12'h555);
        idle(6);
        send(320, 0, 8'h01, 12'hBAD);
        send(0, 240, 8'h01, 12'hBAD);
        send(3, 1, 8'h20, 12'h5A5);
        idle(8);
        check("directed_drained", exp_q.size(), 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0) idle(1);
            x = $urandom_range(0, 7);
            y = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0: x = $urandom_range(SCREEN_WIDTH, 511);
                1: y = $urandom_range(SCREEN_HEIGHT, 255);
                default: ;
            endcase
            send(x, y, $urandom_range(0, 255), $urandom_range(0, 4095));
        end
        idle(10);
        check("random_drained", exp_q.size(), 0);

        abort_clear(12'h0F0, 1001);
        abort_clear(12'h3C3, 500);
        idle(5);
        check("no_spurious_done", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/depth_tester.md
Name: depth_tester

Overview:
- Sits directly downstream of fragment_shader.
- Takes shaded fragments (x, y, z, rgb) and performs a per-pixel depth test against an internal 8-bit z-buffer.
- Writes passing fragments to the framebuffer write port and updates the z-buffer.
- Also provides a frame-start clear sweep that resets the z-buffer to far-plane and fills the framebuffer with a background colour.

Parameters:
- WIDTH, 320, screen width in pixels; x >= WIDTH is out of range.
- HEIGHT, 240, screen height in pixels; y >= HEIGHT is out of range.
- RAM_LATENCY, 2, z-buffer read latency in cycles.
- Z_FAR, 8'hFF, z-buffer clear value.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-low
- valid_in  input  1  fragment valid (from fragment_shader valid_out)
- x_in  input  9  pixel x
- y_in  input  8  pixel y
- z_in  input  8  depth; smaller is nearer
- rgb_in  input  12  fragment colour
- ready_out  output  1  block accepts fragments this cycle
- clear_in  input  1  single-cycle request to start a clear sweep
- bg_rgb_in  input  12  colour written to framebuffer during clear (sampled at clear start)
- busy_out  output  1  clear in progress (DRAIN or CLEAR state)
- clear_done_out  output  1  one-cycle pulse when the sweep completes
- fb_we_out  output  1  framebuffer write strobe
- fb_addr_out  output  17  framebuffer address, y*WIDTH + x
- fb_data_out  output  12  framebuffer write data

Behaviour:
- Reset (rst_in == 0 at a clock edge):
  - All outputs go to 0: ready_out=0, busy_out=0, clear_done_out=0, fb_we_out=0, fb_addr_out=0, fb_data_out=0.
  - In-flight fragments are discarded and the FSM returns to IDLE.
  - ready_out rises to 1 on the first cycle after reset is released.
  - z-buffer contents are undefined after reset; a clear is required before rendering.
- Acceptance:
  - A fragment is accepted when valid_in && ready_out.
  - valid_in while ready_out == 0 is ignored (fragment dropped); upstream must not do this.
  - Out-of-range fragments (x >= WIDTH or y >= HEIGHT) are accepted, then discarded with no z-buffer or framebuffer write.
- Pipeline (one fragment per cycle, no stalls):
  - Stage A registers addr = y*WIDTH + x, z and rgb, and issues the z-buffer read.
  - RAM_LATENCY cycles later, stage C compares.
  - Pass condition: z_in < stored_z (strict). Equal depth fails.
  - On pass, in the same cycle: z-buffer is written with z_in; fb_we_out=1, fb_addr_out=addr, fb_data_out=rgb.
  - Latency: fragment sampled at edge N appears on fb_*_out after edge N+2+RAM_LATENCY (4 cycles by default).
  - fb_we_out is 0 whenever there is no passing fragment at stage C.
- Hazard forwarding:
  - When stage C writes address A, every in-flight fragment whose address is A has its stored_z replaced by the written z.
  - A fragment entering stage A in the same cycle also sees the write.
  - Result: back-to-back fragments to one pixel give the same outcome as fully serialised processing.
- Clear FSM, states IDLE, DRAIN, CLEAR:
  - IDLE: ready_out=1. If clear_in, latch bg_rgb_in and go to DRAIN; ready_out drops on the next cycle.
  - If clear_in and valid_in are both high in IDLE, the fragment is accepted and the clear still starts.
  - DRAIN: ready_out=0, busy_out=1. Wait until all stages are empty, then go to CLEAR with counter=0.
  - CLEAR: each cycle, write Z_FAR to z-buffer[counter] and assert fb_we_out=1, fb_addr_out=counter, fb_data_out=latched background colour.
  - CLEAR takes exactly WIDTH*HEIGHT cycles; the counter goes 0..WIDTH*HEIGHT-1.
  - After writing the last address: pulse clear_done_out for one cycle, go to IDLE, busy_out=0, ready_out=1.
  - clear_in is ignored outside IDLE.
  - Reset during DRAIN or CLEAR aborts immediately to IDLE; the partial clear is not resumed.

Decomposition:
- Shared package graphics_pkg holds:
  - SCREEN_WIDTH=320, SCREEN_HEIGHT=240, FB_ADDR_W=17, Z_W=8, RGB_W=12
  - typedef fragment_t (x, y, z, rgb)
  - typedef fb_addr_t
- One sub-module, zbuffer_ram: single-clock simple dual-port RAM, WIDTH*HEIGHT x 8, one write port and one read port.
  - Read latency RAM_LATENCY.
  - Read-during-write to the same address returns old data; forwarding in depth_tester covers this case.

Test Plan:
- Reset, then clear with bg_rgb_in=12'h00F:
  - busy_out high; exactly 76800 fb writes, addresses 0..76799, data 12'h00F.
  - clear_done_out pulses once, then ready_out=1.
- After clear, fragment (x=10, y=2, z=8'h40, rgb=12'hABC):
  - 4 cycles later fb_we_out=1, fb_addr_out=650, fb_data_out=12'hABC.
- Back-to-back same pixel (5,5): z=8'h80/12'h111, then z=8'h70/12'h222, then z=8'h70/12'h333:
  - First two written on consecutive cycles; the third is rejected (equal depth).
  - The first two writes must pass without the third being written.
- Same pixel (5,5), decreasing then increasing: z=8'h30, then z=8'h50:
  - Only the z=8'h30 fragment is written (forwarding check).
- Out of range: x=320 y=0, and x=0 y=240:
  - No fb_we_out; a following in-range fragment is unaffected.
- Mid-clear reset:
  - Assert rst_in=0 at counter=1000: fb_we_out=0 next cycle, busy_out=0.
  - New clear_in restarts the sweep from address 0.
